dct_block_scheduler: RTL and testbench

DCT_BLOCK_SCHEDULER -- requirements
Module: dct_block_scheduler

---
 rtl/dct_block_scheduler.sv | 118 +++++++++++
 tb/tb_dct_block_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_scheduler.sv
// Ping-pong scheduler that feeds 8x8 blocks from two input banks through a single DCT
// into two output banks, with per-block DCT reset, run timeout and completion counting.
module dct_block_scheduler #(
    parameter int DCT_RST_CYCLES = 2,
    parameter int TIMEOUT        = 1023
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [1:0]  blk_ready,
    output logic [1:0]  blk_release,
    output logic        dct_nreset,
    input  logic [5:0]  dct_fetch_addr,
    output logic [6:0]  src_raddr,
    input  logic [5:0]  dct_result_addr,
    input  logic        dct_result_wren,
    output logic [6:0]  out_waddr,
    output logic        out_wren,
    input  logic        dct_finished,
    output logic [1:0]  out_valid,
    input  logic [1:0]  out_consume,
    output logic        busy,
    output logic        err,
    output logic [15:0] blocks_done
);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    localparam logic [3:0]  RST_LAST = 4'(DCT_RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        in_sel;
    logic        out_sel;
    logic        last_in;
    logic        success;
    logic [3:0]  rst_cnt;
    logic [15:0] run_cnt;
    logic        pick;
    logic [1:0]  valid_set;

    // Round-robin: the bank not served last wins if it is ready.
    assign pick = blk_ready[~last_in] ? ~last_in : last_in;

    assign valid_set = (state == DONE && success) ? (out_sel ? 2'b10 : 2'b01) : 2'b00;

    assign src_raddr = {in_sel, dct_fetch_addr};
    assign out_waddr = {out_sel, dct_result_addr};
    assign out_wren  = dct_result_wren && (state == RUN);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            in_sel      <= 1'b0;
            out_sel     <= 1'b0;
            last_in     <= 1'b1;
            success     <= 1'b0;
            rst_cnt     <= 4'd0;
            run_cnt     <= 16'd0;
            blk_release <= 2'b00;
            dct_nreset  <= 1'b0;
            out_valid   <= 2'b00;
            busy        <= 1'b0;
            err         <= 1'b0;
            blocks_done <= 16'd0;
        end else begin
            blk_release <= 2'b00;
            // A completion set on the same bank as a consume takes priority.
            out_valid   <= (out_valid & ~out_consume) | valid_set;
            case (state)
                IDLE: begin
                    if ((blk_ready != 2'b00) && !out_valid[out_sel]) begin
                        state   <= RST;
                        in_sel  <= pick;
                        rst_cnt <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= RUN;
                        run_cnt    <= 16'd0;
                        dct_nreset <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (dct_finished) begin
                        state       <= DONE;
                        success     <= 1'b1;
                        dct_nreset  <= 1'b0;
                        blk_release <= in_sel ? 2'b10 : 2'b01;
                    end else if (run_cnt == RUN_LAST) begin
                        state       <= DONE;
                        success     <= 1'b0;
                        err         <= 1'b1;
                        dct_nreset  <= 1'b0;
                        blk_release <= in_sel ? 2'b10 : 2'b01;
                    end else begin
                        run_cnt <= run_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    last_in <= in_sel;
                    // An aborted block leaves the output bank selected so it is rewritten.
                    if (success) begin
                        out_sel     <= ~out_sel;
                        blocks_done <= blocks_done + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: block-level reference model compared every cycle,
// plus directed scenarios with literal expectations; a second instance uses a short timeout.
module tb_dct_block_scheduler;

    localparam int RST_CYC  = 2;
    localparam int TO_MAIN  = 1023;
    localparam int TO_SHORT = 50;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [1:0]  blk_ready = 2'b00;
    logic [5:0]  dct_fetch_addr = 6'd0;
    logic [5:0]  dct_result_addr = 6'd0;
    logic        dct_result_wren = 1'b0;
    logic        dct_finished = 1'b0;
    logic [1:0]  out_consume = 2'b00;

    logic [1:0]  blk_release, to_blk_release;
    logic        dct_nreset, to_dct_nreset;
    logic [6:0]  src_raddr, to_src_raddr;
    logic [6:0]  out_waddr, to_out_waddr;
    logic        out_wren, to_out_wren;
    logic [1:0]  out_valid, to_out_valid;
    logic        busy, to_busy;
    logic        err, to_err;
    logic [15:0] blocks_done, to_blocks_done;

    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    bit   auto_consume = 1'b0;
    bit   fin_force = 1'b0;
    int   fin_delay = 0;
    logic [1:0] man_consume = 2'b00;
    int   cyc = 0;
    int   run_seen = 0;

    always #5 clock = ~clock;

    dct_block_scheduler #(.DCT_RST_CYCLES(RST_CYC), .TIMEOUT(TO_MAIN)) dut (
        .clock(clock), .nreset(nreset), .blk_ready(blk_ready), .blk_release(blk_release),
        .dct_nreset(dct_nreset), .dct_fetch_addr(dct_fetch_addr), .src_raddr(src_raddr),
        .dct_result_addr(dct_result_addr), .dct_result_wren(dct_result_wren),
        .out_waddr(out_waddr), .out_wren(out_wren), .dct_finished(dct_finished),
        .out_valid(out_valid), .out_consume(out_consume), .busy(busy), .err(err),
        .blocks_done(blocks_done)
    );

    dct_block_scheduler #(.DCT_RST_CYCLES(RST_CYC), .TIMEOUT(TO_SHORT)) dut_to (
        .clock(clock), .nreset(nreset), .blk_ready(blk_ready), .blk_release(to_blk_release),
        .dct_nreset(to_dct_nreset), .dct_fetch_addr(dct_fetch_addr), .src_raddr(to_src_raddr),
        .dct_result_addr(dct_result_addr), .dct_result_wren(dct_result_wren),
        .out_waddr(to_out_waddr), .out_wren(to_out_wren), .dct_finished(1'b0),
        .out_valid(to_out_valid), .out_consume(out_consume), .busy(to_busy), .err(to_err),
        .blocks_done(to_blocks_done)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] ready, input logic [1:0] consume);
        @(posedge clock);
        #1;
        blk_ready   = ready;
        man_consume = consume;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        nreset       = 1'b0;
        blk_ready    = 2'b00;
        man_consume  = 2'b00;
        auto_consume = 1'b0;
        fin_force    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    task automatic wait_release(input int budget, output logic [1:0] rel, output logic wsel);
        rel  = 2'b00;
        wsel = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (blk_release != 2'b00) begin
                rel  = blk_release;
                wsel = out_waddr[6];
                return;
            end
        end
    endtask

    // DCT and consumer stand-in: finishes fin_delay cycles into a run, fetch address tracks run progress.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            if (dct_nreset === 1'b1) run_seen++;
            else run_seen = 0;
            dct_finished    = fin_force || (fin_delay > 0 && run_seen > fin_delay);
            dct_fetch_addr  = run_seen[5:0];
            dct_result_addr = cyc[6:1];
            dct_result_wren = cyc[0];
            out_consume     = auto_consume ? out_valid : man_consume;
        end
    end

    // Reference model in block terms: age counts cycles since a block was accepted.
    bit         m_active = 1'b0;
    int         m_age = 0;
    int         m_end = -1;
    bit         m_ok = 1'b0;
    bit         m_bank = 1'b0;
    bit         m_last = 1'b1;
    bit         m_osel = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_ovalid = 2'b00;
    logic [15:0] m_done = 16'd0;

    initial begin
        logic [1:0] nv;
        forever begin
            @(posedge clock or negedge nreset);
            if (!nreset) begin
                m_active = 1'b0; m_age = 0; m_end = -1; m_ok = 1'b0; m_bank = 1'b0;
                m_last = 1'b1; m_osel = 1'b0; m_err = 1'b0; m_ovalid = 2'b00; m_done = 16'd0;
            end else begin
                nv = m_ovalid & ~out_consume;
                if (!m_active) begin
                    if ((blk_ready != 2'b00) && !m_ovalid[m_osel]) begin
                        m_active = 1'b1;
                        m_age    = 0;
                        m_end    = -1;
                        m_bank   = blk_ready[!m_last] ? !m_last : m_last;
                    end
                end else if (m_end >= 0 && m_age == m_end) begin
                    m_active = 1'b0;
                    m_last   = m_bank;
                    if (m_ok) begin
                        nv[m_osel] = 1'b1;
                        m_osel     = !m_osel;
                        m_done     = m_done + 16'd1;
                    end
                end else begin
                    if (m_age >= RST_CYC) begin
                        if (dct_finished) begin
                            m_end = m_age + 1;
                            m_ok  = 1'b1;
                        end else if (m_age - RST_CYC == TO_MAIN - 1) begin
                            m_end = m_age + 1;
                            m_ok  = 1'b0;
                            m_err = 1'b1;
                        end
                    end
                    m_age++;
                end
                m_ovalid = nv;
            end
        end
    end

    initial begin
        bit         in_run;
        logic [1:0] exp_rel;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                in_run  = m_active && m_age >= RST_CYC && (m_end < 0 || m_age < m_end);
                exp_rel = (m_active && m_end >= 0 && m_age == m_end) ? (m_bank ? 2'b10 : 2'b01) : 2'b00;
                check_output("model_busy", busy, m_active);
                check_output("model_dct_nreset", dct_nreset, in_run);
                check_output("model_blk_release", blk_release, exp_rel);
                check_output("model_out_valid", out_valid, m_ovalid);
                check_output("model_err", err, m_err);
                check_output("model_blocks_done", blocks_done, m_done);
                check_output("model_src_raddr", src_raddr, {m_bank, dct_fetch_addr});
                check_output("model_out_waddr", out_waddr, {m_osel, dct_result_addr});
                check_output("model_out_wren", out_wren, dct_result_wren && in_run);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] rel;
        logic       wsel;
        logic       err_pre;
        int         lat, low, runs;
        bit         found;

        repeat (3) @(posedge clock);
        #1;
        nreset = 1'b1;
        chk_en = 1'b1;

        $display("[TB] single block");
        @(negedge clock);
        check_output("rst_busy", busy, 0);
        check_output("rst_dct_nreset", dct_nreset, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_blocks_done", blocks_done, 0);
        check_output("rst_err", err, 0);
        check_output("rst_out_sel", out_waddr[6], 0);
        fin_delay = 200;
        apply_stimulus(2'b01, 2'b00);
        lat = 0;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (dct_nreset === 1'b1) break;
            lat++;
            if (busy === 1'b1) low++;
        end
        check_output("start_latency", lat, 3);
        check_output("dct_reset_low_cycles", low, 2);
        wait_release(400, rel, wsel);
        check_output("single_release", rel, 2'b01);
        check_output("single_out_bank", wsel, 0);
        apply_stimulus(2'b00, 2'b00);
        @(negedge clock);
        check_output("single_release_once", blk_release, 0);
        check_output("single_out_valid", out_valid, 2'b01);
        check_output("single_blocks_done", blocks_done, 1);
        check_output("single_out_sel", out_waddr[6], 1);

        $display("[TB] both banks ready, prompt consumer");
        do_reset();
        auto_consume = 1'b1;
        fin_delay    = 20;
        apply_stimulus(2'b11, 2'b00);
        for (int b = 0; b < 4; b++) begin
            wait_release(200, rel, wsel);
            check_output("rr_release", rel, b[0] ? 2'b10 : 2'b01);
            check_output("rr_out_bank", wsel, b[0]);
        end
        @(negedge clock);
        check_output("rr_blocks_done", blocks_done, 4);
        apply_stimulus(2'b00, 2'b00);

        $display("[TB] back-pressure");
        do_reset();
        fin_delay = 10;
        apply_stimulus(2'b11, 2'b00);
        wait_release(100, rel, wsel);
        check_output("bp_release0", rel, 2'b01);
        wait_release(100, rel, wsel);
        check_output("bp_release1", rel, 2'b10);
        repeat (6) @(negedge clock);
        check_output("bp_out_valid", out_valid, 2'b11);
        check_output("bp_busy", busy, 0);
        check_output("bp_blocks_done", blocks_done, 2);
        apply_stimulus(2'b11, 2'b01);
        apply_stimulus(2'b11, 2'b00);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check_output("bp_third_started", found, 1);
        check_output("bp_third_out_bank", out_waddr[6], 0);
        check_output("bp_third_out_valid", out_valid, 2'b10);
        apply_stimulus(2'b00, 2'b00);

        $display("[TB] timeout");
        do_reset();
        fin_delay = 0;
        apply_stimulus(2'b01, 2'b00);
        runs    = 0;
        rel     = 2'b00;
        err_pre = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (to_blk_release != 2'b00) begin
                rel = to_blk_release;
                break;
            end
            if (to_dct_nreset === 1'b1) begin
                runs++;
                err_pre = to_err;
                check_output("to_src_raddr", to_src_raddr, {1'b0, dct_fetch_addr});
                check_output("to_out_waddr", to_out_waddr, {1'b0, dct_result_addr});
                check_output("to_out_wren", to_out_wren, dct_result_wren);
            end
        end
        check_output("to_run_cycles", runs, TO_SHORT);
        check_output("to_err_before", err_pre, 0);
        check_output("to_release", rel, 2'b01);
        check_output("to_err_set", to_err, 1);
        apply_stimulus(2'b00, 2'b00);
        @(negedge clock);
        check_output("to_out_valid", to_out_valid, 0);
        check_output("to_blocks_done", to_blocks_done, 0);
        check_output("to_err_sticky", to_err, 1);
        check_output("to_busy", to_busy, 0);
        check_output("to_out_sel_kept", to_out_waddr[6], 0);

        $display("[TB] address muxing and ignored inputs");
        do_reset();
        auto_consume = 1'b1;
        fin_delay    = 200;
        @(posedge clock);
        #1;
        fin_force = 1'b1;
        repeat (3) @(negedge clock);
        check_output("fin_idle_busy", busy, 0);
        check_output("fin_idle_blocks", blocks_done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (dct_result_wren === 1'b1) break;
        end
        check_output("wren_idle_in", dct_result_wren, 1);
        check_output("wren_idle_out", out_wren, 0);
        @(posedge clock);
        #1;
        fin_force = 1'b0;
        apply_stimulus(2'b10, 2'b00);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (dct_nreset === 1'b1 && dct_fetch_addr == 6'h2A) begin
                found = 1'b1;
                break;
            end
        end
        check_output("fetch_2a_seen", found, 1);
        check_output("src_raddr_bank1", src_raddr, 7'h6A);
        wait_release(300, rel, wsel);
        check_output("bank1_release", rel, 2'b10);
        apply_stimulus(2'b00, 2'b00);

        $display("[TB] reset mid-run");
        do_reset();
        fin_delay = 0;
        apply_stimulus(2'b01, 2'b00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (dct_nreset === 1'b1) break;
        end
        repeat (100) @(posedge clock);
        #1;
        nreset = 1'b0;
        #1;
        check_output("midrst_dct_nreset", dct_nreset, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_release", blk_release, 0);
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_blocks_done", blocks_done, 0);
        blk_ready = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        nreset = 1'b1;
        repeat (5) @(negedge clock);
        check_output("post_rst_blocks_done", blocks_done, 0);
        check_output("post_rst_out_valid", out_valid, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
